// File: rtl/hello_scroll_ctrl.sv
// hello_scroll_ctrl
// Sequencing controller for the six-position HELLO rotating display. Owns the
// 3-bit rotation select feeding the six 6-to-1 character muxes. In RUN the
// select advances on a programmable prescaled tick; in PAUSE it advances once
// per rising edge of step. load_en forces a direct position load.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   run       in   1 = RUN, 0 = PAUSE (async, synchronized here)
//   dir       in   0 = forward (increment), 1 = reverse (decrement) (async)
//   step      in   single-step request, rising edge acts in PAUSE only (async)
//   speed     in   prescaler period = TICK_DIV >> speed cycles (async)
//   load_en   in   while high, sel is forced to load_val (async)
//   load_val  in   position to load; 6 and 7 load 0 (async)
//   sel       out  rotation position 0..5
//   tick      out  one-cycle pulse on every advance
//   wrap      out  one-cycle pulse with tick on 5->0 (fwd) or 0->5 (rev)
//   running   out  1 in RUN state
module hello_scroll_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  input  logic [1:0] speed,
  input  logic       load_en,
  input  logic [2:0] load_val,
  output logic [2:0] sel,
  output logic       tick,
  output logic       wrap,
  output logic       running
);

  // pcnt never exceeds TICK_DIV-1
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic       run;
    logic       dir;
    logic       step;
    logic [1:0] speed;
    logic       load_en;
    logic [2:0] load_val;
  } ctl_t;

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  ctl_t          ctl_raw, ctl_m_q, ctl_s_q;
  logic          step_d_q;
  logic [1:0]    speed_d_q;
  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic [31:0]   period;
  logic          last, step_pulse, spd_chg, advance;
  logic [2:0]    nxt_pos, load_pos;

  assign ctl_raw = '{run: run, dir: dir, step: step, speed: speed,
                     load_en: load_en, load_val: load_val};

  // 2-flop synchronizers for every async control, plus one more stage on
  // step (edge detect) and speed (change detect)
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ctl_m_q   <= '0;
      ctl_s_q   <= '0;
      step_d_q  <= 1'b0;
      speed_d_q <= 2'd0;
    end else begin
      ctl_m_q   <= ctl_raw;
      ctl_s_q   <= ctl_m_q;
      step_d_q  <= ctl_s_q.step;
      speed_d_q <= ctl_s_q.speed;
    end
  end

  // FSM: state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= PAUSE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSE:   if (ctl_s_q.run)  state_d = RUN;
      RUN:     if (!ctl_s_q.run) state_d = PAUSE;
      default: state_d = PAUSE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running = (state_q == RUN);
    sel     = sel_q;
    tick    = tick_q;
    wrap    = wrap_q;
  end

  // Datapath: prescaler, advance and load
  always_comb begin
    period = TICK_DIV >> ctl_s_q.speed;
    if (period == 32'd0) period = 32'd1;   // tiny TICK_DIV at high speed
    last       = (32'(pcnt_q) == period - 32'd1);
    step_pulse = ctl_s_q.step & ~step_d_q;
    spd_chg    = (ctl_s_q.speed != speed_d_q);

    // load dominates; a speed change restarts the period without advancing
    advance = 1'b0;
    if (!ctl_s_q.load_en) begin
      if (state_q == RUN) advance = last & ~spd_chg;
      else                advance = step_pulse;
    end

    pcnt_d = '0;
    if (state_q == RUN && !ctl_s_q.load_en && !spd_chg && !last)
      pcnt_d = pcnt_q + PW'(1);

    if (ctl_s_q.dir) nxt_pos = (sel_q == 3'd0) ? 3'd5 : sel_q - 3'd1;
    else             nxt_pos = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;

    load_pos = (ctl_s_q.load_val > 3'd5) ? 3'd0 : ctl_s_q.load_val;

    sel_d = sel_q;
    if (ctl_s_q.load_en) sel_d = load_pos;
    else if (advance)    sel_d = nxt_pos;

    tick_d = advance;
    wrap_d = advance & (ctl_s_q.dir ? (sel_q == 3'd0) : (sel_q == 3'd5));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pcnt_q <= '0;
      sel_q  <= 3'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
module tb_hello_scroll_ctrl;

  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       run = 1'b0, dir = 1'b0, step = 1'b0, load_en = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] sel;
  logic       tick, wrap, running;

  hello_scroll_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk), .resetn(resetn), .run(run), .dir(dir), .step(step),
    .speed(speed), .load_en(load_en), .load_val(load_val),
    .sel(sel), .tick(tick), .wrap(wrap), .running(running)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs as sampled at each edge; logic reacting at edge j sees the input
  // present at edge j-2 (two synchronizer stages), with the one before it
  // used for edge/change detection.
  typedef struct packed {
    logic       run;
    logic       dir;
    logic       step;
    logic [1:0] speed;
    logic       load_en;
    logic [2:0] load_val;
  } in_t;

  typedef struct {
    int sel;
    bit wrap;
  } exp_t;

  in_t  h1 = '0, h2 = '0, h3 = '0;
  bit   m_run = 0, m_tick = 0, m_wrap = 0;
  int   m_sel = 0, m_elapsed = 0;
  exp_t sbq[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_run = 0; m_sel = 0; m_elapsed = 0; m_tick = 0; m_wrap = 0;
      sbq.delete();
    end else begin
      in_t  e, ep;
      bit   adv;
      int   n, nxt;
      exp_t x;
      e = h2; ep = h3; adv = 0; m_tick = 0; m_wrap = 0;
      n = TD >> e.speed;
      if (n < 1) n = 1;
      if (e.load_en) begin
        m_sel = (e.load_val > 5) ? 0 : int'(e.load_val);
        m_elapsed = 0;
      end else if (m_run) begin
        if (e.speed != ep.speed) m_elapsed = 0;   // restart period, no advance
        else begin
          m_elapsed++;
          if (m_elapsed >= n) begin adv = 1; m_elapsed = 0; end
        end
      end else begin
        m_elapsed = 0;
        adv = e.step && !ep.step;
      end
      if (adv) begin
        nxt    = e.dir ? (m_sel + 5) % 6 : (m_sel + 1) % 6;
        m_wrap = e.dir ? (m_sel == 0) : (m_sel == 5);
        m_sel  = nxt;
        m_tick = 1;
        x.sel  = nxt;
        x.wrap = m_wrap;
        sbq.push_back(x);
      end
      m_run = e.run;
      h3 = h2; h2 = h1;
      h1 = {run, dir, step, speed, load_en, load_val};
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (resetn) begin
      chk("sel", 32'(sel), 32'(m_sel));
      chk("running", 32'(running), 32'(m_run));
      chk("tick", 32'(tick), 32'(m_tick));
      if (tick) begin
        if (sbq.size() == 0) begin
          chk("tick_unexpected", 32'(tick), 32'd0);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          chk("tick_sel", 32'(sel), 32'(x.sel));
          chk("tick_wrap", 32'(wrap), 32'(x.wrap));
        end
      end else begin
        chk("wrap_idle", 32'(wrap), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    cyc(3);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    resetn = 1'b1;
    cyc(100);                                   // idle, run=0

    run = 1'b1; cyc(60);                        // forward auto-scroll
    dir = 1'b1; speed = 2'd2; cyc(20);          // reverse, fast
    speed = 2'd0; cyc(30);                      // slow down mid-period

    run = 1'b0; dir = 1'b0; cyc(6);             // step in pause
    step = 1'b1; cyc(20); step = 1'b0; cyc(5);
    step = 1'b1; cyc(5);  step = 1'b0; cyc(5);

    run = 1'b1; cyc(4);                         // steps ignored in RUN
    for (int i = 0; i < 5; i++) begin
      step = 1'b1; cyc(2); step = 1'b0; cyc(3);
    end

    run = 1'b0; cyc(5);                         // loads
    load_val = 3'd4; load_en = 1'b1; cyc(3); load_en = 1'b0; cyc(5);
    load_val = 3'd7; load_en = 1'b1; cyc(3); load_en = 1'b0; cyc(5);

    run = 1'b1; load_val = 3'd2; cyc(10);       // load straddling a due advance
    load_en = 1'b1; cyc(10); load_en = 1'b0; cyc(30);

    for (int i = 0; i < 3000; i++) begin       // randomized
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 5)  == 0) step = ~step;
      if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) load_en = ~load_en;
      load_val = 3'($urandom_range(0, 7));
      cyc(1);
    end

    // mid-run asynchronous reset once sel reaches 3
    load_en = 1'b0; step = 1'b0; run = 1'b1; dir = 1'b0; speed = 2'd0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(1);
      if (sel == 3'd3) found = 1;
    end
    chk("reach_sel3", 32'(found), 32'd1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 32'd0);
    chk("async_rst_running", 32'(running), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_wrap", 32'(wrap), 32'd0);
    run = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(10);
    run = 1'b1; cyc(40);

    run = 1'b0; cyc(8);                         // drain
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
